// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, opcodes,
// function codes, datapath select encodings and the decoded instruction class.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDWAIT = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    localparam logic [2:0] WD_ALU = 3'd0;
    localparam logic [2:0] WD_MEM = 3'd1;
    localparam logic [2:0] WD_PC  = 3'd2;
    localparam logic [2:0] WD_HI  = 3'd3;
    localparam logic [2:0] WD_LO  = 3'd4;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    localparam logic [1:0] LT_WORD  = 2'd0;
    localparam logic [1:0] LT_BYTE  = 2'd1;
    localparam logic [1:0] LT_HALF  = 2'd2;
    localparam logic [1:0] LT_BYTEU = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    typedef enum logic [3:0] {
        IC_NONE, IC_J, IC_JAL, IC_JR, IC_ADDU, IC_SUBU, IC_ORI, IC_LUI,
        IC_LOAD, IC_SW, IC_BEQ, IC_BNE, IC_BLEZ, IC_MULDIV, IC_MFHI, IC_MFLO
    } iclass_t;

    typedef struct packed {
        iclass_t    iclass;
        logic       rtype;
        logic [1:0] load_type;
        logic [1:0] md_op;
    } dec_t;

    // MDWAIT runs while the counter counts down to zero inclusive, hence LAT-1.
    function automatic logic [7:0] lat_preload(input int lat);
        return 8'(lat - 1);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/function decode into an instruction class plus the
// load-extension and mult/div sub-op fields; unknown encodings map to IC_NONE.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec       = '0;
        dec.rtype = (op == OP_RTYPE);
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_NOP:   dec.iclass = IC_NONE;
                    FN_JR:    dec.iclass = IC_JR;
                    FN_ADDU:  dec.iclass = IC_ADDU;
                    FN_SUBU:  dec.iclass = IC_SUBU;
                    FN_MFHI:  dec.iclass = IC_MFHI;
                    FN_MFLO:  dec.iclass = IC_MFLO;
                    FN_MULT:  begin dec.iclass = IC_MULDIV; dec.md_op = MD_MULT;  end
                    FN_MULTU: begin dec.iclass = IC_MULDIV; dec.md_op = MD_MULTU; end
                    FN_DIV:   begin dec.iclass = IC_MULDIV; dec.md_op = MD_DIV;   end
                    FN_DIVU:  begin dec.iclass = IC_MULDIV; dec.md_op = MD_DIVU;  end
                    default:  dec.iclass = IC_NONE;
                endcase
            end
            OP_J:    dec.iclass = IC_J;
            OP_JAL:  dec.iclass = IC_JAL;
            OP_BEQ:  dec.iclass = IC_BEQ;
            OP_BNE:  dec.iclass = IC_BNE;
            OP_BLEZ: dec.iclass = IC_BLEZ;
            OP_ORI:  dec.iclass = IC_ORI;
            OP_LUI:  dec.iclass = IC_LUI;
            OP_LW:   begin dec.iclass = IC_LOAD; dec.load_type = LT_WORD;  end
            OP_LB:   begin dec.iclass = IC_LOAD; dec.load_type = LT_BYTE;  end
            OP_LH:   begin dec.iclass = IC_LOAD; dec.load_type = LT_HALF;  end
            OP_LBU:  begin dec.iclass = IC_LOAD; dec.load_type = LT_BYTEU; end
            OP_SW:   dec.iclass = IC_SW;
            default: dec.iclass = IC_NONE;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle controller FSM: FETCH/DECODE/EXEC/MEM/WB plus a counted MDWAIT.
// Outputs are combinational from state and IR fields and are forced low during reset.
module multi_cycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       lez,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic [1:0] ext_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [2:0] wd_sel,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] load_type,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       md_busy,
    output logic [2:0] state
);

    dec_t       dec;
    state_t     st;
    logic [7:0] cnt;
    logic       taken;
    logic       is_div;

    mc_decode u_decode (
        .op    (op),
        .funct (funct),
        .dec   (dec)
    );

    assign state  = st;
    assign is_div = (dec.md_op == MD_DIV) || (dec.md_op == MD_DIVU);

    always_comb begin
        case (dec.iclass)
            IC_BEQ:  taken = zero;
            IC_BNE:  taken = !zero;
            IC_BLEZ: taken = lez;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st  <= S_FETCH;
            cnt <= 8'd0;
        end else begin
            case (st)
                S_FETCH: st <= S_DECODE;
                S_DECODE: begin
                    case (dec.iclass)
                        IC_NONE, IC_J, IC_JAL, IC_JR: st <= S_FETCH;
                        default:                      st <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (dec.iclass)
                        IC_LOAD, IC_SW: st <= S_MEM;
                        IC_ADDU, IC_SUBU, IC_ORI, IC_LUI, IC_MFHI, IC_MFLO: st <= S_WB;
                        IC_MULDIV: begin
                            st  <= S_MDWAIT;
                            cnt <= is_div ? lat_preload(DIV_LAT) : lat_preload(MULT_LAT);
                        end
                        default: st <= S_FETCH;
                    endcase
                end
                S_MEM: st <= (dec.iclass == IC_SW) ? S_FETCH : S_WB;
                S_WB:  st <= S_FETCH;
                S_MDWAIT: begin
                    // Leaving on zero means the counter is already cleared for next time.
                    if (cnt == 8'd0) st  <= S_FETCH;
                    else             cnt <= cnt - 8'd1;
                end
                default: st <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write  = 1'b0;
        pc_src    = PC_PLUS4;
        ir_write  = 1'b0;
        alu_op    = ALU_ADD;
        alu_src   = 1'b0;
        ext_op    = EXT_ZERO;
        reg_write = 1'b0;
        reg_dst   = RD_RT;
        wd_sel    = WD_ALU;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        load_type = LT_WORD;
        md_start  = 1'b0;
        md_op     = MD_MULT;
        md_busy   = 1'b0;
        if (!reset) begin
            case (st)
                S_FETCH: begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_PLUS4;
                end
                S_DECODE: begin
                    case (dec.iclass)
                        IC_J: begin
                            pc_write = 1'b1;
                            pc_src   = PC_JUMP;
                        end
                        IC_JAL: begin
                            pc_write  = 1'b1;
                            pc_src    = PC_JUMP;
                            reg_write = 1'b1;
                            reg_dst   = RD_RA;
                            wd_sel    = WD_PC;
                        end
                        IC_JR: begin
                            pc_write = 1'b1;
                            pc_src   = PC_REG;
                        end
                        default: ;
                    endcase
                end
                S_EXEC: begin
                    case (dec.iclass)
                        IC_ADDU: alu_op = ALU_ADD;
                        IC_SUBU: alu_op = ALU_SUB;
                        IC_ORI: begin
                            alu_op  = ALU_OR;
                            ext_op  = EXT_ZERO;
                            alu_src = 1'b1;
                        end
                        IC_LUI: begin
                            alu_op  = ALU_LUI;
                            ext_op  = EXT_UPPER;
                            alu_src = 1'b1;
                        end
                        IC_LOAD, IC_SW: begin
                            alu_op  = ALU_ADD;
                            ext_op  = EXT_SIGN;
                            alu_src = 1'b1;
                        end
                        IC_BEQ, IC_BNE, IC_BLEZ: begin
                            alu_op   = ALU_SUB;
                            ext_op   = EXT_SIGN;
                            pc_write = taken;
                            pc_src   = taken ? PC_BRANCH : PC_PLUS4;
                        end
                        IC_MULDIV: begin
                            md_start = 1'b1;
                            md_op    = dec.md_op;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dec.iclass == IC_SW) begin
                        mem_write = 1'b1;
                    end else begin
                        mem_read  = 1'b1;
                        load_type = dec.load_type;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = dec.rtype ? RD_RD : RD_RT;
                    case (dec.iclass)
                        IC_LOAD: begin
                            wd_sel    = WD_MEM;
                            mem_read  = 1'b1;
                            load_type = dec.load_type;
                        end
                        IC_MFHI: wd_sel = WD_HI;
                        IC_MFLO: wd_sel = WD_LO;
                        default: wd_sel = WD_ALU;
                    endcase
                end
                S_MDWAIT: md_busy = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Table-driven bench for multi_cycle_ctrl: per-cycle expected state and outputs are
// queued when an instruction is driven and popped as the controller steps through it.
module tb_multi_cycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic [2:0] alu_op;
        logic       alu_src;
        logic [1:0] ext_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [2:0] wd_sel;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] load_type;
        logic       md_start;
        logic [1:0] md_op;
        logic       md_busy;
    } out_t;

    typedef struct packed {
        logic [2:0] st;
        out_t       o;
    } exp_t;

    typedef enum int {R_JMP, R_WB, R_MEM, R_SW, R_BR} route_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       lez;
        route_t     route;
        out_t       d;
        out_t       e;
        out_t       m;
        out_t       w;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, lez;
    logic       pc_write, ir_write, alu_src, reg_write, mem_read, mem_write;
    logic       md_start, md_busy;
    logic [1:0] pc_src, ext_op, reg_dst, load_type, md_op;
    logic [2:0] alu_op, wd_sel, state;

    exp_t sb[$];
    vec_t vecs[$];
    out_t fo, z0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .lez(lez),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .alu_op(alu_op),
        .alu_src(alu_src), .ext_op(ext_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .wd_sel(wd_sel), .mem_read(mem_read), .mem_write(mem_write), .load_type(load_type),
        .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .state(state)
    );

    function automatic out_t mk(logic pw, logic [1:0] ps, logic [2:0] ao, logic asrc,
                                logic [1:0] eo, logic rw, logic [1:0] rd, logic [2:0] ws,
                                logic mr, logic mw, logic [1:0] lt);
        out_t r = '0;
        r.pc_write = pw;  r.pc_src  = ps;  r.alu_op = ao;  r.alu_src   = asrc;
        r.ext_op   = eo;  r.reg_write = rw; r.reg_dst = rd; r.wd_sel   = ws;
        r.mem_read = mr;  r.mem_write = mw; r.load_type = lt;
        return r;
    endfunction

    function automatic out_t sample();
        out_t r;
        r.pc_write = pc_write;   r.pc_src    = pc_src;    r.ir_write  = ir_write;
        r.alu_op   = alu_op;     r.alu_src   = alu_src;   r.ext_op    = ext_op;
        r.reg_write = reg_write; r.reg_dst   = reg_dst;   r.wd_sel    = wd_sel;
        r.mem_read = mem_read;   r.mem_write = mem_write; r.load_type = load_type;
        r.md_start = md_start;   r.md_op     = md_op;     r.md_busy   = md_busy;
        return r;
    endfunction

    task automatic push(input logic [2:0] st, input out_t o);
        exp_t x;
        x.st = st;
        x.o  = o;
        sb.push_back(x);
    endtask

    task automatic check_cycle(input string tag, input int cyc);
        exp_t x, g;
        g.st = state;
        g.o  = sample();
        checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s cyc%0d: scoreboard empty, got st=%0d out=%h", tag, cyc, g.st, g.o);
        end else begin
            x = sb.pop_front();
            if (g !== x)
                $display("FAIL %s cyc%0d: got st=%0d out=%h, expected st=%0d out=%h",
                         tag, cyc, g.st, g.o, x.st, x.o);
            else
                passed++;
        end
    endtask

    task automatic drain(input string tag);
        int n = sb.size();
        for (int k = 0; k < n; k++) begin
            #2;
            check_cycle(tag, k);
            @(negedge clk);
        end
    endtask

    task automatic add(input string nm, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic l, input route_t r,
                       input out_t d, input out_t e, input out_t m, input out_t w);
        vec_t v;
        v.name = nm; v.op = o; v.funct = f; v.zero = z; v.lez = l; v.route = r;
        v.d = d; v.e = e; v.m = m; v.w = w;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        op = v.op; funct = v.funct; zero = v.zero; lez = v.lez;
        push(3'd0, fo);
        push(3'd1, v.d);
        if (v.route != R_JMP)                      push(3'd2, v.e);
        if (v.route == R_MEM || v.route == R_SW)   push(3'd3, v.m);
        if (v.route == R_WB  || v.route == R_MEM)  push(3'd4, v.w);
        drain(v.name);
    endtask

    task automatic run_md(input string nm, input logic [5:0] f, input logic [1:0] mo,
                          input int lat);
        out_t e, b;
        op = 6'h00; funct = f; zero = 1'b0; lez = 1'b0;
        e = '0; e.md_start = 1'b1; e.md_op = mo;
        b = '0; b.md_busy = 1'b1;
        push(3'd0, fo);
        push(3'd1, z0);
        push(3'd2, e);
        for (int k = 0; k < lat; k++) push(3'd5, b);
        drain(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

    initial begin
        out_t e, b, ema, wrd, wrt;
        z0 = '0;
        fo = '0; fo.ir_write = 1'b1; fo.pc_write = 1'b1;
        ema = mk(0, 2'd0, 3'd0, 1, 2'd1, 0, 2'd0, 3'd0, 0, 0, 2'd0);
        wrd = mk(0, 2'd0, 3'd0, 0, 2'd0, 1, 2'd1, 3'd0, 0, 0, 2'd0);
        wrt = mk(0, 2'd0, 3'd0, 0, 2'd0, 1, 2'd0, 3'd0, 0, 0, 2'd0);

        add("addu", 6'h00, 6'h21, 0, 0, R_WB, z0, mk(0,2'd0,3'd0,0,2'd0,0,2'd0,3'd0,0,0,2'd0), z0, wrd);
        add("subu", 6'h00, 6'h23, 0, 0, R_WB, z0, mk(0,2'd0,3'd1,0,2'd0,0,2'd0,3'd0,0,0,2'd0), z0, wrd);
        add("ori",  6'h0D, 6'h21, 0, 0, R_WB, z0, mk(0,2'd0,3'd2,1,2'd0,0,2'd0,3'd0,0,0,2'd0), z0, wrt);
        add("lui",  6'h0F, 6'h00, 0, 0, R_WB, z0, mk(0,2'd0,3'd3,1,2'd2,0,2'd0,3'd0,0,0,2'd0), z0, wrt);
        add("lw",   6'h23, 6'h00, 0, 0, R_MEM, z0, ema, mk(0,2'd0,3'd0,0,2'd0,0,2'd0,3'd0,1,0,2'd0),
            mk(0,2'd0,3'd0,0,2'd0,1,2'd0,3'd1,1,0,2'd0));
        add("lb",   6'h20, 6'h00, 0, 0, R_MEM, z0, ema, mk(0,2'd0,3'd0,0,2'd0,0,2'd0,3'd0,1,0,2'd1),
            mk(0,2'd0,3'd0,0,2'd0,1,2'd0,3'd1,1,0,2'd1));
        add("lh",   6'h21, 6'h00, 0, 0, R_MEM, z0, ema, mk(0,2'd0,3'd0,0,2'd0,0,2'd0,3'd0,1,0,2'd2),
            mk(0,2'd0,3'd0,0,2'd0,1,2'd0,3'd1,1,0,2'd2));
        add("lbu",  6'h24, 6'h00, 0, 0, R_MEM, z0, ema, mk(0,2'd0,3'd0,0,2'd0,0,2'd0,3'd0,1,0,2'd3),
            mk(0,2'd0,3'd0,0,2'd0,1,2'd0,3'd1,1,0,2'd3));
        add("sw",   6'h2B, 6'h00, 0, 0, R_SW, z0, ema, mk(0,2'd0,3'd0,0,2'd0,0,2'd0,3'd0,0,1,2'd0), z0);
        add("beq_t",  6'h04, 6'h00, 1, 0, R_BR, z0, mk(1,2'd1,3'd1,0,2'd1,0,2'd0,3'd0,0,0,2'd0), z0, z0);
        add("beq_nt", 6'h04, 6'h00, 0, 1, R_BR, z0, mk(0,2'd0,3'd1,0,2'd1,0,2'd0,3'd0,0,0,2'd0), z0, z0);
        add("bne_t",  6'h05, 6'h00, 0, 0, R_BR, z0, mk(1,2'd1,3'd1,0,2'd1,0,2'd0,3'd0,0,0,2'd0), z0, z0);
        add("bne_nt", 6'h05, 6'h00, 1, 0, R_BR, z0, mk(0,2'd0,3'd1,0,2'd1,0,2'd0,3'd0,0,0,2'd0), z0, z0);
        add("blez_t", 6'h06, 6'h00, 0, 1, R_BR, z0, mk(1,2'd1,3'd1,0,2'd1,0,2'd0,3'd0,0,0,2'd0), z0, z0);
        add("blez_nt",6'h06, 6'h00, 1, 0, R_BR, z0, mk(0,2'd0,3'd1,0,2'd1,0,2'd0,3'd0,0,0,2'd0), z0, z0);
        add("j",    6'h02, 6'h00, 0, 0, R_JMP, mk(1,2'd2,3'd0,0,2'd0,0,2'd0,3'd0,0,0,2'd0), z0, z0, z0);
        add("jal",  6'h03, 6'h00, 0, 0, R_JMP, mk(1,2'd2,3'd0,0,2'd0,1,2'd2,3'd2,0,0,2'd0), z0, z0, z0);
        add("jr",   6'h00, 6'h08, 0, 0, R_JMP, mk(1,2'd3,3'd0,0,2'd0,0,2'd0,3'd0,0,0,2'd0), z0, z0, z0);
        add("nop",  6'h00, 6'h00, 0, 0, R_JMP, z0, z0, z0, z0);
        add("undef_op",    6'h3F, 6'h00, 1, 1, R_JMP, z0, z0, z0, z0);
        add("undef_funct", 6'h00, 6'h3F, 0, 0, R_JMP, z0, z0, z0, z0);
        add("mfhi", 6'h00, 6'h10, 0, 0, R_WB, z0, z0, z0, mk(0,2'd0,3'd0,0,2'd0,1,2'd1,3'd3,0,0,2'd0));
        add("mflo", 6'h00, 6'h12, 0, 0, R_WB, z0, z0, z0, mk(0,2'd0,3'd0,0,2'd0,1,2'd1,3'd4,0,0,2'd0));

        // Reset state: outputs low even though the state register reads FETCH.
        reset = 1'b1; op = 6'h00; funct = 6'h00; zero = 1'b0; lez = 1'b0;
        #2;
        push(3'd0, z0); check_cycle("reset_init", 0);
        @(posedge clk); #2;
        push(3'd0, z0); check_cycle("reset_hold", 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        run_md("mult",  6'h18, 2'd0, 5);
        run_md("multu", 6'h19, 2'd1, 5);
        run_md("div",   6'h1A, 2'd2, 10);
        run_md("divu",  6'h1B, 2'd3, 10);

        // Reset in the third MDWAIT cycle of a div, then a clean addu afterwards.
        op = 6'h00; funct = 6'h1A; zero = 1'b0; lez = 1'b0;
        e = '0; e.md_start = 1'b1; e.md_op = 2'd2;
        b = '0; b.md_busy = 1'b1;
        push(3'd0, fo); push(3'd1, z0); push(3'd2, e);
        push(3'd5, b);  push(3'd5, b);  push(3'd5, b);
        for (int k = 0; k < 6; k++) begin
            #2;
            check_cycle("div_pre_rst", k);
            if (k < 5) @(negedge clk);
        end
        #1 reset = 1'b1;
        #1 push(3'd0, z0); check_cycle("rst_mid_mdwait", 0);
        @(posedge clk); #2;
        push(3'd0, z0); check_cycle("rst_mid_hold", 1);
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[0]);

        push(3'd0, fo);
        #2 check_cycle("final_fetch", 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
